icache_ctrl: RTL

Direct-mapped instruction cache and fill controller sitting directly upstream of the CPU's fetch path inside the memory hierarchy. It takes the PC (`i_addr`) and returns `instr` with `i_rdy`. On a miss it fetches a 4-word line from unified main memory over a request/ready handshake, then delivers the word. It also keeps saturating hit/miss counters for performance runs.

---
 rtl/icache_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding line-fill FSM
// and saturating hit/miss performance counters.
module icache_ctrl #(
  parameter int unsigned LINES = 8,
  parameter int unsigned WPL   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         i_addr,
  output logic [15:0]         instr,
  output logic                i_rdy,
  input  logic                flush,
  output logic                mem_re,
  output logic [15:0]         mem_addr,
  input  logic                mem_rdy,
  input  logic [WPL*16-1:0]   mem_rd_data,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);

  localparam int unsigned OFF_W  = $clog2(WPL);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = 16 - IDX_W - OFF_W;
  localparam int unsigned LINE_W = WPL * 16;

  typedef enum logic [1:0] {
    S_COMPARE,
    S_WAIT,
    S_FILL
  } state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q   [LINES];
  logic [TAG_W-1:0]        tag_d   [LINES];
  logic [LINE_W-1:0]       data_q  [LINES];
  logic [LINE_W-1:0]       data_d  [LINES];
  logic                    mem_re_q, mem_re_d;
  logic [15:0]             mem_addr_q, mem_addr_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;
  logic                    flush_pend_q, flush_pend_d;

  logic [OFF_W-1:0]        lk_off;
  logic [IDX_W-1:0]        lk_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic                    lk_hit;
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        fill_tag;

  // Combinational lookup of the current PC and decode of the latched fill address.
  always_comb begin
    lk_off   = i_addr[OFF_W-1:0];
    lk_idx   = i_addr[OFF_W+IDX_W-1:OFF_W];
    lk_tag   = i_addr[15:OFF_W+IDX_W];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    fill_idx = mem_addr_q[OFF_W+IDX_W-1:OFF_W];
    fill_tag = mem_addr_q[15:OFF_W+IDX_W];
  end

  // Next-state, array update and output logic for the fill FSM.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_re_d     = mem_re_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_pend_d = flush_pend_q;
    i_rdy        = 1'b0;
    instr        = '0;

    case (state_q)
      S_COMPARE: begin
        if (lk_hit) begin
          i_rdy = 1'b1;
          instr = data_q[lk_idx][{lk_off, 4'b0000} +: 16];
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          mem_addr_d             = i_addr;
          mem_addr_d[OFF_W-1:0]  = '0;
          mem_re_d               = 1'b1;
          flush_pend_d           = 1'b0;
          state_d                = S_WAIT;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_rdy) begin
          // A flush seen at any point while waiting leaves the returning line invalid.
          data_d[fill_idx]  = mem_rd_data;
          tag_d[fill_idx]   = fill_tag;
          valid_d[fill_idx] = !(flush || flush_pend_q);
          mem_re_d          = 1'b0;
          state_d           = S_FILL;
        end
      end
      S_FILL: begin
        flush_pend_d = 1'b0;
        state_d      = S_COMPARE;
      end
      default: begin
        mem_re_d = 1'b0;
        state_d  = S_COMPARE;
      end
    endcase

    if (flush) valid_d = '0;
  end

  // Control state, valid bits and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COMPARE;
      valid_q      <= '0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data storage; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LINES; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
